// File: rtl/conv_2d_coef_sched_pkg.sv
// Shared types and sizing helpers for the 2-D convolution coefficient scheduler.
package conv_2d_coef_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_LOAD     = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // Number of coefficients in a square kernel.
  function automatic int coef_amount(input int win_size);
    return win_size * win_size;
  endfunction

  // Bank index width; never narrower than one bit.
  function automatic int bank_width(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/conv_2d_if.sv
// Coefficient write channel into the convolution filter's coefficient bridge.
interface conv_2d_if #(
  parameter int COEF_WIDTH = 13,
  parameter int NUM_W      = 4
);
  logic                  wr_stb;
  logic [NUM_W-1:0]      coef_num;
  logic [COEF_WIDTH-1:0] coef_val;

  modport master (output wr_stb, coef_num, coef_val);
  modport slave  (input  wr_stb, coef_num, coef_val);
endinterface

// File: rtl/conv_2d_coef_bank.sv
// Kernel storage: BANKS x COEF_AMOUNT words, one write port, one
// combinational read port. Out-of-range addresses are ignored on write
// and read back as zero. Contents clear on reset.
module conv_2d_coef_bank
  import conv_2d_coef_sched_pkg::*;
#(
  parameter  int COEF_WIDTH  = 13,
  parameter  int WIN_SIZE    = 3,
  parameter  int BANKS       = 4,
  localparam int COEF_AMOUNT = coef_amount(WIN_SIZE),
  localparam int NUM_W       = $clog2(COEF_AMOUNT),
  localparam int BANK_W      = bank_width(BANKS)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [BANK_W-1:0]     wr_bank_i,
  input  logic [NUM_W-1:0]      wr_num_i,
  input  logic [COEF_WIDTH-1:0] wr_val_i,
  input  logic [BANK_W-1:0]     rd_bank_i,
  input  logic [NUM_W-1:0]      rd_num_i,
  output logic [COEF_WIDTH-1:0] rd_val_o
);

  logic [BANKS-1:0][COEF_AMOUNT-1:0][COEF_WIDTH-1:0] mem_q, mem_d;
  logic wr_ok, rd_ok;

  assign wr_ok = (int'(wr_bank_i) < BANKS) && (int'(wr_num_i) < COEF_AMOUNT);
  assign rd_ok = (int'(rd_bank_i) < BANKS) && (int'(rd_num_i) < COEF_AMOUNT);

  // Apply a single in-range write on top of the current contents.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_i && wr_ok) mem_d[wr_bank_i][wr_num_i] = wr_val_i;
  end

  // Storage register, cleared on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) mem_q <= '0;
    else          mem_q <= mem_d;
  end

  // Combinational read port.
  always_comb begin
    rd_val_o = '0;
    if (rd_ok) rd_val_o = mem_q[rd_bank_i][rd_num_i];
  end

endmodule

// File: rtl/conv_2d_coef_sched.sv
// Coefficient scheduler: holds BANKS kernels and, on commit, streams the
// selected kernel into the filter's coefficient bridge as COEF_AMOUNT
// back-to-back strobes, optionally aligned to start-of-frame.
// Option macro: CONV_2D_COEF_SCHED_FRAME_SYNC_EN -- when defined, the load
// waits for a video start-of-frame handshake; otherwise it starts one cycle
// after leaving IDLE and the video_* inputs are ignored.
// Every commit lands in the one-entry pending slot first; IDLE launches from
// that slot, so a commit is seen by the FSM the cycle after it is presented.
module conv_2d_coef_sched
  import conv_2d_coef_sched_pkg::*;
#(
  parameter  int COEF_WIDTH  = 13,
  parameter  int WIN_SIZE    = 3,
  parameter  int BANKS       = 4,
  localparam int COEF_AMOUNT = coef_amount(WIN_SIZE),
  localparam int NUM_W       = $clog2(COEF_AMOUNT),
  localparam int BANK_W      = bank_width(BANKS)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  bank_wr_i,
  input  logic [BANK_W-1:0]     bank_sel_i,
  input  logic [NUM_W-1:0]      coef_num_i,
  input  logic [COEF_WIDTH-1:0] coef_val_i,
  input  logic                  commit_i,
  input  logic [BANK_W-1:0]     commit_bank_i,
  input  logic                  video_tvalid_i,
  input  logic                  video_tready_i,
  input  logic                  video_tuser_i,
  conv_2d_if.master             conv_2d_ctrl_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [BANK_W-1:0]     active_bank_o,
  output logic                  wr_err_o
);

  localparam logic [NUM_W-1:0] LAST = NUM_W'(COEF_AMOUNT - 1);

  state_e                state_q, state_d;
  logic [NUM_W-1:0]      cnt_q, cnt_d;
  logic [BANK_W-1:0]     target_q, target_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [BANK_W-1:0]     pend_bank_q, pend_bank_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [NUM_W-1:0]      coef_num_q, coef_num_d;
  logic [COEF_WIDTH-1:0] coef_val_q, coef_val_d;
  logic                  done_q, done_d;
  logic [BANK_W-1:0]     active_q, active_d;
  logic                  wr_err_q, wr_err_d;

  logic                  sof;
  logic                  tgt_hit;
  logic                  bank_wr_en;
  logic [COEF_WIDTH-1:0] rd_val;

`ifdef CONV_2D_COEF_SCHED_FRAME_SYNC_EN
  assign sof = video_tvalid_i & video_tready_i & video_tuser_i;
`else
  logic unused_video;
  assign unused_video = video_tvalid_i ^ video_tready_i ^ video_tuser_i;
  assign sof          = 1'b1;
`endif

  // A write aimed at the kernel being streamed is dropped so the bridge never
  // receives a mix of old and new values.
  assign tgt_hit    = bank_wr_i && (state_q == ST_LOAD) && (bank_sel_i == target_q);
  assign bank_wr_en = bank_wr_i && !tgt_hit;

  conv_2d_coef_bank #(
    .COEF_WIDTH (COEF_WIDTH),
    .WIN_SIZE   (WIN_SIZE),
    .BANKS      (BANKS)
  ) u_bank (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (bank_wr_en),
    .wr_bank_i (bank_sel_i),
    .wr_num_i  (coef_num_i),
    .wr_val_i  (coef_val_i),
    .rd_bank_i (target_q),
    .rd_num_i  (cnt_d),
    .rd_val_o  (rd_val)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (pend_vld_q)     state_d = ST_WAIT_SOF;
      ST_WAIT_SOF: if (sof)            state_d = ST_LOAD;
      ST_LOAD:     if (cnt_q == LAST)  state_d = ST_DONE;
      ST_DONE:                         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; outputs are registered from state_d so
  // wr_stb lines up with the cycles the FSM spends in LOAD.
  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_bank_d = pend_bank_q;
    target_d    = target_q;
    cnt_d       = '0;
    if (state_q == ST_IDLE && pend_vld_q) begin
      target_d   = pend_bank_q;
      pend_vld_d = 1'b0;
    end
    // A new commit always wins the slot, replacing any older pending one.
    if (commit_i) begin
      pend_vld_d  = 1'b1;
      pend_bank_d = commit_bank_i;
    end
    if (state_d == ST_LOAD) cnt_d = (state_q == ST_LOAD) ? cnt_q + 1'b1 : '0;
    wr_stb_d   = (state_d == ST_LOAD);
    coef_num_d = wr_stb_d ? cnt_d  : '0;
    coef_val_d = wr_stb_d ? rd_val : '0;
    done_d     = (state_d == ST_DONE);
    active_d   = done_d ? target_q : active_q;
    wr_err_d   = tgt_hit;
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q       <= '0;
      target_q    <= '0;
      pend_vld_q  <= 1'b0;
      pend_bank_q <= '0;
      wr_stb_q    <= 1'b0;
      coef_num_q  <= '0;
      coef_val_q  <= '0;
      done_q      <= 1'b0;
      active_q    <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      pend_vld_q  <= pend_vld_d;
      pend_bank_q <= pend_bank_d;
      wr_stb_q    <= wr_stb_d;
      coef_num_q  <= coef_num_d;
      coef_val_q  <= coef_val_d;
      done_q      <= done_d;
      active_q    <= active_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign conv_2d_ctrl_o.wr_stb   = wr_stb_q;
  assign conv_2d_ctrl_o.coef_num = coef_num_q;
  assign conv_2d_ctrl_o.coef_val = coef_val_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign active_bank_o = active_q;
  assign wr_err_o      = wr_err_q;

endmodule
